// File: rtl/crossbar_pkg.sv
// Shared crossbar helpers used by the ingress decoupler and the egress coupler.
package crossbar_pkg;

  function automatic int cnt_width(input int max_in_transit);
    return $clog2(max_in_transit + 1);
  endfunction

endpackage

// File: rtl/decoupler_credit_counter.sv
// Saturating up/down counter of outstanding masks; ok_o is combinational.
// A same-cycle return (dec_i) frees headroom immediately, so a full counter never stalls a beat that retires one.
module credit_counter
  import crossbar_pkg::*;
#(
  parameter int MAX = 8,
  localparam int W = cnt_width(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic         ok_o,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && (cnt_q != W'(MAX))) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i && !inc_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ok_o  = (cnt_q < W'(MAX)) || dec_i;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/decoupler.sv
// Splits one N-lane beat into N handshaked lane streams plus a {keep,last} mask; 1-cycle latency.
// in_ready_o needs all lane slots free and a mask credit. Optional macro DECOUPLER_CREDIT_CHECK_EN adds err_credit_o.
module decoupler
  import crossbar_pkg::*;
#(
  parameter int NUM_ELEMENTS   = 4,
  parameter int MAX_IN_TRANSIT = 8,
  parameter int DATA_W         = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_ELEMENTS-1:0][DATA_W-1:0]  in_data_i,
  input  logic [NUM_ELEMENTS-1:0]              in_keep_i,
  input  logic                                 in_last_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  output logic [NUM_ELEMENTS-1:0][DATA_W-1:0]  out_data_o,
  output logic [NUM_ELEMENTS-1:0]              out_keep_o,
  output logic [NUM_ELEMENTS-1:0]              out_valid_o,
  input  logic [NUM_ELEMENTS-1:0]              out_ready_i,
  output logic [NUM_ELEMENTS:0]                mask_data_o,
  output logic                                 mask_valid_o,
  input  logic                                 mask_credit_i
`ifdef DECOUPLER_CREDIT_CHECK_EN
  ,
  output logic                                 err_credit_o
`endif
);

  localparam int CW = cnt_width(MAX_IN_TRANSIT);

  typedef struct packed {
    logic [NUM_ELEMENTS-1:0] keep;
    logic                    last;
  } mask_t;

  logic [NUM_ELEMENTS-1:0][DATA_W-1:0] data_q, data_d;
  logic [NUM_ELEMENTS-1:0]             keep_q, keep_d;
  logic [NUM_ELEMENTS-1:0]             lane_vld_q, lane_vld_d;
  logic [NUM_ELEMENTS-1:0]             free;
  mask_t                               mask_q, mask_d;
  logic                                mask_vld_q, mask_vld_d;
  logic                                credit_ok;
  logic                                accept;
  logic [CW-1:0]                       cnt;

  credit_counter #(
    .MAX (MAX_IN_TRANSIT)
  ) u_credit_counter (
    .clk   (clk),
    .rst   (rst),
    .inc_i (accept),
    .dec_i (mask_credit_i),
    .ok_o  (credit_ok),
    .cnt_o (cnt)
  );

  assign free       = ~lane_vld_q | out_ready_i;
  // Every lane must be free, not only kept ones, so a beat never splits across cycles.
  assign in_ready_o = credit_ok && (&free);
  assign accept     = in_valid_i && in_ready_o;

  always_comb begin
    data_d     = data_q;
    keep_d     = keep_q;
    lane_vld_d = lane_vld_q;
    mask_d     = mask_q;
    mask_vld_d = 1'b0;
    for (int i = 0; i < NUM_ELEMENTS; i++) begin
      if (accept) begin
        lane_vld_d[i] = in_keep_i[i];
        keep_d[i]     = in_keep_i[i];
        if (in_keep_i[i]) begin
          data_d[i] = in_data_i[i];
        end
      end else if (out_ready_i[i]) begin
        lane_vld_d[i] = 1'b0;
      end
    end
    if (accept) begin
      mask_d.keep = in_keep_i;
      mask_d.last = in_last_i;
      mask_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      keep_q     <= '0;
      lane_vld_q <= '0;
      mask_q     <= '0;
      mask_vld_q <= 1'b0;
    end else begin
      data_q     <= data_d;
      keep_q     <= keep_d;
      lane_vld_q <= lane_vld_d;
      mask_q     <= mask_d;
      mask_vld_q <= mask_vld_d;
    end
  end

  assign out_data_o   = data_q;
  assign out_keep_o   = keep_q;
  assign out_valid_o  = lane_vld_q;
  assign mask_data_o  = mask_q;
  assign mask_valid_o = mask_vld_q;

`ifdef DECOUPLER_CREDIT_CHECK_EN
  logic err_q, err_d;
  logic underflow, overflow;

  assign underflow = mask_credit_i && !accept && (cnt == '0);
  assign overflow  = accept && !mask_credit_i && (cnt == CW'(MAX_IN_TRANSIT));

  always_comb begin
    err_d = err_q | underflow | overflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_credit_o = err_q;

  a_no_underflow : assert property (@(posedge clk) disable iff (rst) !underflow);
  a_no_overflow  : assert property (@(posedge clk) disable iff (rst) !overflow);
`endif

endmodule

// File: tb/tb_decoupler.sv
// Directed bench for decoupler with N=4, MAX_IN_TRANSIT=2, 8-bit lanes.
module tb_decoupler;

  localparam int N = 4;
  localparam int W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0][W-1:0] in_data;
  logic [N-1:0]      in_keep;
  logic              in_last;
  logic              in_valid;
  logic              in_ready;
  logic [N-1:0][W-1:0] out_data;
  logic [N-1:0]      out_keep;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_ready;
  logic [N:0]        mask_data;
  logic              mask_valid;
  logic              mask_credit;
`ifdef DECOUPLER_CREDIT_CHECK_EN
  logic              err_credit;
`endif

  int total  = 0;
  int passed = 0;

  decoupler #(
    .NUM_ELEMENTS   (N),
    .MAX_IN_TRANSIT (2),
    .DATA_W         (W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data_i     (in_data),
    .in_keep_i     (in_keep),
    .in_last_i     (in_last),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .out_data_o    (out_data),
    .out_keep_o    (out_keep),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .mask_data_o   (mask_data),
    .mask_valid_o  (mask_valid),
    .mask_credit_i (mask_credit)
`ifdef DECOUPLER_CREDIT_CHECK_EN
    ,
    .err_credit_o  (err_credit)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  task automatic drive(input logic [N-1:0] keep, input logic last, input logic [W-1:0] base);
    in_keep = keep;
    in_last = last;
    for (int i = 0; i < N; i++) in_data[i] = base + W'(i);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_keep = '0; in_last = 1'b0; in_data = '0;
    out_ready = 4'hF; mask_credit = 1'b0;
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_mask_valid", 32'(mask_valid), 0);
    chk("rst_mask_data", 32'(mask_data), 0);
    chk("rst_cnt", 32'(dut.cnt), 0);
    chk("rst_lane_data", 32'(out_data), 0);
    rst = 1'b0; #1;
    chk("idle_ready", 32'(in_ready), 1);

    // Three beats at full rate, credits returned alongside beats two and three.
    drive(4'b1111, 1'b0, 8'h10); in_valid = 1'b1; tick();
    chk("t1a_valid", 32'(out_valid), 32'hF);
    chk("t1a_d0", 32'(out_data[0]), 32'h10);
    chk("t1a_d3", 32'(out_data[3]), 32'h13);
    chk("t1a_mvalid", 32'(mask_valid), 1);
    chk("t1a_mask", 32'(mask_data), 32'h1E);
    chk("t1a_cnt", 32'(dut.cnt), 1);
    drive(4'b0101, 1'b0, 8'h20); mask_credit = 1'b1; tick();
    chk("t1b_valid", 32'(out_valid), 32'h5);
    chk("t1b_d0", 32'(out_data[0]), 32'h20);
    chk("t1b_d2", 32'(out_data[2]), 32'h22);
    chk("t1b_mask", 32'(mask_data), 32'h0A);
    chk("t1b_cnt", 32'(dut.cnt), 1);
    drive(4'b1000, 1'b1, 8'h30); tick();
    chk("t1c_valid", 32'(out_valid), 32'h8);
    chk("t1c_keep", 32'(out_keep), 32'h8);
    chk("t1c_d3", 32'(out_data[3]), 32'h33);
    chk("t1c_mask", 32'(mask_data), 32'h11);
    chk("t1c_cnt", 32'(dut.cnt), 1);
    in_valid = 1'b0; tick();
    chk("t1d_cnt", 32'(dut.cnt), 0);
    chk("t1d_valid", 32'(out_valid), 0);
    chk("t1d_mvalid", 32'(mask_valid), 0);
    mask_credit = 1'b0;

    // Credit exhaustion and same-cycle re-enable.
    drive(4'b0001, 1'b0, 8'h40); in_valid = 1'b1; tick();
    chk("t2a_cnt", 32'(dut.cnt), 1);
    drive(4'b0010, 1'b0, 8'h50); #1;
    chk("t2b_ready", 32'(in_ready), 1);
    tick();
    chk("t2b_cnt", 32'(dut.cnt), 2);
    chk("t2b_valid", 32'(out_valid), 32'h2);
    drive(4'b0100, 1'b0, 8'h60); #1;
    chk("t2c_ready_lo", 32'(in_ready), 0);
    tick();
    chk("t2c_cnt", 32'(dut.cnt), 2);
    chk("t2c_valid", 32'(out_valid), 0);
    chk("t2c_mvalid", 32'(mask_valid), 0);
    chk("t2c_ready_still_lo", 32'(in_ready), 0);
    mask_credit = 1'b1; #1;
    chk("t2d_ready_credit", 32'(in_ready), 1);
    tick();
    chk("t2d_cnt", 32'(dut.cnt), 2);
    chk("t2d_valid", 32'(out_valid), 32'h4);
    chk("t2d_d2", 32'(out_data[2]), 32'h62);
    chk("t2d_mask", 32'(mask_data), 32'h08);
    in_valid = 1'b0; tick();
    chk("t2e_cnt", 32'(dut.cnt), 1);
    tick();
    chk("t2f_cnt", 32'(dut.cnt), 0);
    mask_credit = 1'b0;

    // Lane 2 stalls for five cycles.
    out_ready = 4'b1011;
    drive(4'b1111, 1'b0, 8'h70); in_valid = 1'b1; tick();
    chk("t3a_cnt", 32'(dut.cnt), 1);
    chk("t3a_valid", 32'(out_valid), 32'hF);
    drive(4'b1111, 1'b0, 8'h80);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t3_stall_ready", 32'(in_ready), 0);
      chk("t3_stall_v2", 32'(out_valid[2]), 1);
      chk("t3_stall_d2", 32'(out_data[2]), 32'h72);
      tick();
    end
    chk("t3_others_drained", 32'(out_valid), 32'h4);
    out_ready = 4'hF; #1;
    chk("t3b_ready_rise", 32'(in_ready), 1);
    tick();
    chk("t3b_cnt", 32'(dut.cnt), 2);
    chk("t3b_valid", 32'(out_valid), 32'hF);
    chk("t3b_d2", 32'(out_data[2]), 32'h82);
    chk("t3b_d0", 32'(out_data[0]), 32'h80);
    in_valid = 1'b0; mask_credit = 1'b1; tick(); tick();
    chk("t3c_cnt", 32'(dut.cnt), 0);
    mask_credit = 1'b0;

    // Empty beat carrying only last.
    drive(4'b0000, 1'b1, 8'h00); in_valid = 1'b1; tick();
    chk("t4_valid", 32'(out_valid), 0);
    chk("t4_mvalid", 32'(mask_valid), 1);
    chk("t4_mask", 32'(mask_data), 32'h01);
    chk("t4_cnt", 32'(dut.cnt), 1);

    // Reset while three lanes are pending.
    out_ready = 4'h0;
    drive(4'b0111, 1'b0, 8'h90); tick();
    in_valid = 1'b0;
    chk("t5a_cnt", 32'(dut.cnt), 2);
    chk("t5a_valid", 32'(out_valid), 32'h7);
    tick();
    chk("t5b_held", 32'(out_valid), 32'h7);
    chk("t5b_d1", 32'(out_data[1]), 32'h91);
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    chk("t5c_valid", 32'(out_valid), 0);
    chk("t5c_mvalid", 32'(mask_valid), 0);
    chk("t5c_cnt", 32'(dut.cnt), 0);
    chk("t5c_ready", 32'(in_ready), 1);
    out_ready = 4'hF;

`ifdef DECOUPLER_CREDIT_CHECK_EN
    chk("t6_err_clear", 32'(err_credit), 0);
    mask_credit = 1'b1; tick();
    mask_credit = 1'b0;
    chk("t6_err_set", 32'(err_credit), 1);
    tick();
    chk("t6_err_sticky", 32'(err_credit), 1);
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    chk("t6_err_rst", 32'(err_credit), 0);
`else
    mask_credit = 1'b1; tick();
    mask_credit = 1'b0;
    chk("t6_underflow_cnt", 32'(dut.cnt), 0);
    chk("t6_underflow_ready", 32'(in_ready), 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
